// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_arbiter
// Description : Round-robin arbiter that shares one bitwise/logical operator
//               unit between NREQ requesters. The granted request's result
//               is registered and held behind a valid/ready response port.
//               A wrapping counter tracks completed responses.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               req_valid/req_ready   - per-requester handshake (ready one-hot)
//               req_op/req_a/req_b    - packed per-requester opcode/operands
//               res_valid/res_ready   - response handshake
//               res_data/res_id       - 4-bit result and owning requester
//               ops_done              - completed response count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [5*NREQ-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [3:0]          res_data,
    output logic [ID_W-1:0]     res_id,
    output logic [CNT_W-1:0]    ops_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [3:0]       r_res_data;
    logic [ID_W-1:0]  r_res_id;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_gnt_found;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_scan_idx;
    logic [2:0]       w_op;
    logic [3:0]       w_a;
    logic [4:0]       w_b;
    logic [3:0]       w_result;
    logic             w_take;
    logic             w_done;

    // Operator unit. A is zero-extended to 5 bits for bitwise ops and the
    // result truncated to 4 bits, so B[4] only matters for logical ops.
    function automatic logic [3:0] compute_op(input logic [2:0] op,
                                              input logic [3:0] a,
                                              input logic [4:0] b);
        logic [4:0] a5;
        logic [4:0] r5;
        a5 = {1'b0, a};
        r5 = '0;
        case (op)
            3'd0:    r5 = ~a5;
            3'd1:    r5 = a5 & b;
            3'd2:    r5 = a5 | b;
            3'd3:    r5 = a5 ^ b;
            3'd4:    r5 = a5 ~^ b;
            3'd5:    r5 = {4'b0000, (a == 4'd0)};
            3'd6:    r5 = {4'b0000, ((a != 4'd0) && (b != 5'd0))};
            default: r5 = {4'b0000, ((a != 4'd0) || (b != 5'd0))};
        endcase
        return r5[3:0];
    endfunction

    // Round-robin search starting at r_rr_ptr; the ID_W-bit add wraps
    // naturally because NREQ is a power of two.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = r_rr_ptr + ID_W'(k);
            if (!w_gnt_found && req_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    assign w_op     = req_op[3*w_gnt_idx +: 3];
    assign w_a      = req_a[4*w_gnt_idx +: 4];
    assign w_b      = req_b[5*w_gnt_idx +: 5];
    assign w_result = compute_op(w_op, w_a, w_b);

    assign w_take = (r_state == S_IDLE) && w_gnt_found;
    assign w_done = (r_state == S_RESP) && res_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = S_RESP;
            S_RESP:  if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. Ready is forced low while reset is held so the grant
    // never leaks out before the block is running.
    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_gnt_found && !rst) begin
                req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
            end
        end else begin
            res_valid = 1'b1;
        end
    end

    // Datapath: result capture, pointer advance and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_res_data <= '0;
            r_res_id   <= '0;
            r_ops_done <= '0;
        end else begin
            if (w_take) begin
                r_res_data <= w_result;
                r_res_id   <= w_gnt_idx;
                r_rr_ptr   <= w_gnt_idx + ID_W'(1);
            end
            if (w_done) begin
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
        end
    end

    assign res_data = r_res_data;
    assign res_id   = r_res_id;
    assign ops_done = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_op_arbiter
// Description : Directed self-checking bench for logic_op_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_op_arbiter;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [4*NREQ-1:0] req_a;
    logic [5*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_data;
    logic [ID_W-1:0]   res_id;
    logic [CNT_W-1:0]  ops_done;

    int n_checks;
    int n_errors;

    logic [3:0] held_data;
    logic [1:0] held_id;

    logic [3:0] exp_tab [8];

    logic_op_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from requester id (res_ready assumed high) and check
    // grant, result, owner and return to idle. Called at a negedge in IDLE.
    task automatic run_op(input int id, input logic [2:0] op, input logic [3:0] a,
                          input logic [4:0] b, input logic [3:0] exp);
        int cyc;
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        req_op[3*id +: 3]  = op;
        req_a[4*id +: 4]   = a;
        req_b[5*id +: 5]   = b;
        #1;
        check("grant", {28'd0, req_ready}, 32'd1 << id);
        cyc = 0;
        @(negedge clk);
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("res_data", {28'd0, res_data}, {28'd0, exp});
        check("res_id", {30'd0, res_id}, id);
        @(negedge clk);
        check("res_valid_clr", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        exp_tab[0] = 4'b1011; exp_tab[1] = 4'b0000; exp_tab[2] = 4'b0111; exp_tab[3] = 4'b0111;
        exp_tab[4] = 4'b1000; exp_tab[5] = 4'b0000; exp_tab[6] = 4'b0001; exp_tab[7] = 4'b0001;

        repeat (2) @(negedge clk);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {28'd0, res_data}, 32'd0);
        check("rst_res_id", {30'd0, res_id}, 32'd0);
        check("rst_ops_done", {24'd0, ops_done}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Idle with no requests: nothing happens
        repeat (3) @(negedge clk);
        check("idle_valid", {31'd0, res_valid}, 32'd0);

        // Requester 0, A=4, B=3, all opcodes
        for (int i = 0; i < 8; i++) begin
            run_op(0, 3'(i), 4'd4, 5'd3, exp_tab[i]);
        end
        check("ops_done_8", {24'd0, ops_done}, 32'd8);

        // Requester 2: B[4] ignored by AND, counted by LAND
        run_op(2, 3'd1, 4'd4, 5'b10100, 4'b0100);
        run_op(2, 3'd6, 4'd4, 5'b10100, 4'b0001);

        // Requester 1: A=0, B=10000
        run_op(1, 3'd7, 4'd0, 5'b10000, 4'b0001);
        run_op(1, 3'd6, 4'd0, 5'b10000, 4'b0000);
        run_op(1, 3'd5, 4'd0, 5'b10000, 4'b0001);
        check("ops_done_13", {24'd0, ops_done}, 32'd13);

        // Fairness: fresh reset so the pointer starts at 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[3*i +: 3] = 3'd2;          // OR with B=0 returns A
            req_a[4*i +: 4]  = 4'(i + 8);
            req_b[5*i +: 5]  = 5'd0;
        end
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 6; g++) begin
            check("rr_grant", {28'd0, req_ready}, 32'd1 << (g % 4));
            @(negedge clk);
            check("rr_valid", {31'd0, res_valid}, 32'd1);
            check("rr_id", {30'd0, res_id}, g % 4);
            check("rr_data", {28'd0, res_data}, (g % 4) + 8);
            check("rr_ready_resp", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
            #1;
            check("rr_gap", {31'd0, res_valid}, 32'd0);
        end
        req_valid = '0;
        check("ops_done_6", {24'd0, ops_done}, 32'd6);

        // Backpressure: hold result for 10 cycles; pointer is at 2
        res_ready = 1'b0;
        req_valid = 4'b1000;
        req_op[9 +: 3]  = 3'd3;
        req_a[12 +: 4]  = 4'b1010;
        req_b[15 +: 5]  = 5'b00110;
        #1;
        check("bp_grant", {28'd0, req_ready}, 32'b1000);
        @(negedge clk);
        req_valid = 4'b0111;
        held_data = 4'b1100;
        held_id   = 2'd3;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_data", {28'd0, res_data}, {28'd0, held_data});
            check("bp_id", {30'd0, res_id}, {30'd0, held_id});
            check("bp_ready", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check("bp_ops_hold", {24'd0, ops_done}, 32'd6);
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {31'd0, res_valid}, 32'd0);
        check("bp_ops_done", {24'd0, ops_done}, 32'd7);

        // Reset in the middle of a response
        res_ready = 1'b0;
        req_valid = 4'b0001;
        req_op[0 +: 3] = 3'd0;
        req_a[0 +: 4]  = 4'd5;
        @(negedge clk);
        req_valid = '0;
        check("mid_valid", {31'd0, res_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_data", {28'd0, res_data}, 32'd0);
        check("mid_rst_id", {30'd0, res_id}, 32'd0);
        check("mid_rst_ops", {24'd0, ops_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid_rst_ptr", {28'd0, req_ready}, 32'b0001);
        req_valid = '0;
        @(negedge clk);

        // Counter wrap: 255 operations, then the 256th
        for (int i = 0; i < 255; i++) begin
            run_op(i % 4, 3'd1, 4'hF, 5'h1F, 4'hF);
        end
        check("ops_255", {24'd0, ops_done}, 32'd255);
        run_op(3, 3'd4, 4'b0101, 5'b10011, 4'b1001);
        check("ops_wrap", {24'd0, ops_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one bitwise/logical operator unit between NREQ requesters.
- Operators: NOT, AND, OR, XOR, XNOR, logical NOT, logical AND, logical OR.
- Operand A is 4 bits and operand B is 5 bits.
- Round-robin arbitration grants one request at a time. The block computes and registers the 4-bit result, then holds it behind a valid/ready response port.
- Sits between the test/sequencer masters and the operator datapath. Also keeps a wrapping count of completed operations.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- ID_W, 2, requester index width; must equal log2(NREQ).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  3*NREQ  opcode of requester i at bits [3i+2:3i].
- req_a  input  4*NREQ  operand A of requester i at bits [4i+3:4i].
- req_b  input  5*NREQ  operand B of requester i at bits [5i+4:5i].
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  4  result value.
- res_id  output  ID_W  index of the requester that owns the result.
- ops_done  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Opcodes:
  - 0 = ~A
  - 1 = A&B
  - 2 = A|B
  - 3 = A^B
  - 4 = A~^B
  - 5 = !A
  - 6 = A&&B
  - 7 = A||B
- Width rules:
  - A is zero-extended to 5 bits before every bitwise op; the result is truncated to bits [3:0], so B[4] never affects a bitwise result.
  - Logical ops test the full operands: A is nonzero over 4 bits, B is nonzero over 5 bits, so B=5'b10000 counts as true.
  - The 1-bit logical result is zero-extended to 4 bits (0000 or 0001).
- FSM with two states, IDLE and RESP. Reset state is IDLE.
- Reset values:
  - req_ready=0, res_valid=0, res_data=0, res_id=0, ops_done=0.
  - Round-robin pointer rr_ptr=0.
- IDLE:
  - Grant goes to the first asserted req_valid, searching from index rr_ptr upward with wrap-around.
  - req_ready is the one-hot grant, combinational from req_valid and rr_ptr. It is all zero when no request is valid.
  - On an edge with a grant: capture res_data = op(granted operands) and res_id = grant, set res_valid=1, go to RESP, set rr_ptr = (grant+1) mod NREQ.
- RESP:
  - req_ready is all zero.
  - res_valid=1; res_data and res_id stay stable until the handshake.
  - On an edge with res_ready=1: clear res_valid, increment ops_done, go to IDLE.
- Latency and throughput:
  - A request accepted at edge N gives res_valid high from edge N to edge N+1 at the earliest.
  - A new grant can occur at earliest on the edge after the response handshake, so throughput is at most one operation per 2 cycles.
- Requester rules:
  - A requester must hold valid, op and operands stable until its req_ready is seen.
  - A requester may drop req_valid while not granted; the arbiter does not remember it.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NREQ-1 grants.
- Boundary cases:
  - res_ready held high in RESP: response completes in 1 cycle.
  - res_ready low for a long time: result held indefinitely, no grants issued.
  - ops_done at its maximum value wraps to 0.
  - Reset asserted mid-RESP immediately clears res_valid and discards the pending result. ops_done is not incremented, and rr_ptr returns to 0.
  - req_valid all zero in IDLE: stay in IDLE, rr_ptr unchanged.

Test Plan:
- Single requester 0, A=4, B=3, ops 0..7 in sequence with res_ready=1 → res_data = 1011, 0000, 0111, 0111, 1000, 0000, 0001, 0001; res_id=0; ops_done=8.
- Requester 2 issues A=4, B=5'b10100 with AND, then with LAND → 0100 (B[4] ignored), then 0001.
- Requester 1 issues A=0, B=5'b10000 with LOR, then with LAND, then with LNOT → 0001, 0000, 0001.
- All 4 requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0,1; each res_id matches the grant; response available every 2nd cycle.
- res_ready held low 10 cycles after a grant → res_valid stays 1, res_data/res_id constant, req_ready all zero; ops_done increments once on release.
- Reset pulsed while in RESP, and ops_done preloaded to 255 by 255 transactions before a 256th → outputs clear immediately on reset; the 256th response makes ops_done wrap to 0.
